// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master arbiter for the bridge CPU data port. Master 0 has
//            fixed priority; a saturating starvation counter forces a grant
//            to master 1 after STARVE_LIMIT lost arbitrations. Each accepted
//            request is issued on the bus for one cycle and acknowledged the
//            cycle after, carrying the sampled read data.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [3:0] C_STARVE_LIMIT = STARVE_LIMIT[3:0];
  localparam logic [3:0] C_STARVE_MAX   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        win1_d;
  logic        win1_q;
  logic [31:0] rdata_q;
  logic        m0_ack_q;
  logic        m1_ack_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_byteen_q;
  logic        busy_q;

  // Winner selection and starvation-counter next value for the IDLE cycle
  always_comb begin
    win1_d   = m1_req & (~m0_req | (starve_q >= C_STARVE_LIMIT));
    starve_d = starve_q;
    if (!m1_req || win1_d) begin
      starve_d = 4'd0;
    end else if (starve_q != C_STARVE_MAX) begin
      // m1 requested and lost to m0
      starve_d = starve_q + 4'd1;
    end
  end

  // Arbitration FSM; bus drive, ack and busy are all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      starve_q     <= 4'd0;
      win1_q       <= 1'b0;
      rdata_q      <= 32'd0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      bus_byteen_q <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      // Bus and acks are single-cycle pulses unless set below
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      bus_byteen_q <= 4'd0;
      busy_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          starve_q <= starve_d;
          if (m0_req || m1_req) begin
            // The bus registers double as the payload latch for ISSUE
            win1_q       <= win1_d;
            bus_addr_q   <= win1_d ? m1_addr   : m0_addr;
            bus_wdata_q  <= win1_d ? m1_wdata  : m0_wdata;
            bus_byteen_q <= win1_d ? m1_byteen : m0_byteen;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Bridge read data is combinational on bus_addr; sample it now
          rdata_q  <= bus_rdata;
          m0_ack_q <= ~win1_q;
          m1_ack_q <= win1_q;
          busy_q   <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_ack_q ? rdata_q : 32'd0;
  assign m1_rdata   = m1_ack_q ? rdata_q : 32'd0;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_byteen = bus_byteen_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter with a simple
//            combinational bridge model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_byteen  (m0_byteen),
    .m0_ack     (m0_ack),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_byteen  (m1_byteen),
    .m1_ack     (m1_ack),
    .m1_rdata   (m1_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bridge model: one fixed word at 0x1000, otherwise an address-derived pattern
  assign bus_rdata = (bus_addr == 32'h0000_1000) ? 32'hDEAD_BEEF
                                                 : (bus_addr ^ 32'hA5A5_0000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " m0_ack"},     {31'd0, m0_ack}, 32'd0);
    check({tag, " m1_ack"},     {31'd0, m1_ack}, 32'd0);
    check({tag, " m0_rdata"},   m0_rdata, 32'd0);
    check({tag, " m1_rdata"},   m1_rdata, 32'd0);
    check({tag, " bus_addr"},   bus_addr, 32'd0);
    check({tag, " bus_wdata"},  bus_wdata, 32'd0);
    check({tag, " bus_byteen"}, {28'd0, bus_byteen}, 32'd0);
    check({tag, " busy"},       {31'd0, busy}, 32'd0);
  endtask

  // One isolated transaction from master m, checked cycle by cycle
  task automatic run_txn(input string tag, input int m, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata);
    if (m == 0) begin
      m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_byteen = be;
    end else begin
      m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_byteen = be;
    end
    tick();  // ISSUE
    check({tag, " issue bus_addr"},   bus_addr, addr);
    check({tag, " issue bus_wdata"},  bus_wdata, wdata);
    check({tag, " issue bus_byteen"}, {28'd0, bus_byteen}, {28'd0, be});
    check({tag, " issue busy"},       {31'd0, busy}, 32'd1);
    check({tag, " issue acks"},       {30'd0, m1_ack, m0_ack}, 32'd0);
    tick();  // RESP
    check({tag, " resp m0_ack"},      {31'd0, m0_ack}, (m == 0) ? 32'd1 : 32'd0);
    check({tag, " resp m1_ack"},      {31'd0, m1_ack}, (m == 1) ? 32'd1 : 32'd0);
    check({tag, " resp rdata"},       (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
    check({tag, " resp other rdata"}, (m == 0) ? m1_rdata : m0_rdata, 32'd0);
    check({tag, " resp bus_byteen"},  {28'd0, bus_byteen}, 32'd0);
    check({tag, " resp busy"},        {31'd0, busy}, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();  // IDLE
    check_quiet({tag, " idle"});
  endtask

  initial begin
    reset     = 1'b0;
    m0_req    = 1'b1;
    m0_addr   = 32'h0000_1000;
    m0_wdata  = 32'd0;
    m0_byteen = 4'd0;
    m1_req    = 1'b1;
    m1_addr   = 32'h0000_2000;
    m1_wdata  = 32'd0;
    m1_byteen = 4'd0;

    // Reset held for two edges with both requests high
    tick();
    check_quiet("rst1");
    tick();
    check_quiet("rst2");

    // Release: first IDLE edge grants m0 (priority, counter 0)
    reset = 1'b1;
    tick();
    check("post-rst busy",     {31'd0, busy}, 32'd1);
    check("post-rst bus_addr", bus_addr, 32'h0000_1000);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    check("post-rst m0_ack",   {31'd0, m0_ack}, 32'd1);
    check("post-rst m1_ack",   {31'd0, m1_ack}, 32'd0);
    tick();
    check_quiet("post-rst idle");

    // Single read and single write
    run_txn("m0 read",  0, 32'h0000_1000, 32'd0,         4'h0, 32'hDEAD_BEEF);
    run_txn("m1 write", 1, 32'h0000_7F00, 32'h1234_5678, 4'hF, 32'hA5A5_7F00);

    // Priority and starvation: both held, expected winners m0 x4, m1, m0
    m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h0000_0200; m1_byteen = 4'h0;
    for (int g = 0; g < 6; g++) begin
      automatic logic exp_m1 = (g == 4);
      tick();
      check($sformatf("starve g%0d bus_addr", g), bus_addr,
            exp_m1 ? 32'h0000_0200 : 32'h0000_0100);
      tick();
      check($sformatf("starve g%0d acks", g), {30'd0, m1_ack, m0_ack},
            exp_m1 ? 32'd2 : 32'd1);
      check($sformatf("starve g%0d rdata", g), exp_m1 ? m1_rdata : m0_rdata,
            exp_m1 ? 32'hA5A5_0200 : 32'hA5A5_0100);
      tick();
      check($sformatf("starve g%0d idle busy", g), {31'd0, busy}, 32'd0);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    check_quiet("starve drain");

    // Payload change during ISSUE has no effect
    m0_req = 1'b1; m0_addr = 32'h0000_3000; m0_byteen = 4'h0;
    tick();
    m0_addr = 32'h0000_4444;
    #1;
    check("stable bus_addr", bus_addr, 32'h0000_3000);
    tick();
    check("stable m0_ack",   {31'd0, m0_ack}, 32'd1);
    check("stable m0_rdata", m0_rdata, 32'hA5A5_3000);
    m0_req = 1'b0;
    tick();

    // Reset during ISSUE of a write aborts it
    m1_req = 1'b1; m1_addr = 32'h0000_7F04; m1_wdata = 32'hCAFE_0001; m1_byteen = 4'h3;
    tick();
    check("abort issue byteen", {28'd0, bus_byteen}, 32'd3);
    reset = 1'b0;
    tick();
    check_quiet("abort rst");
    reset  = 1'b1;
    m1_req = 1'b0;
    tick();
    check_quiet("abort after1");
    tick();
    check_quiet("abort after2");

    // Arbiter back in IDLE accepts a new request
    run_txn("recover", 0, 32'h0000_1000, 32'd0, 4'h0, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
